// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, keeps one I-cache request in flight
// and buffers responses in a DEPTH-entry FIFO. Optional counters: `IF_FETCH_PERF_EN.
module if_fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0,
    parameter logic [XLEN-1:0] NOP      = 32'h00000013
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            fetch_enable,
    input  logic            combined_stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            icache_req_valid,
    output logic [XLEN-1:0] icache_req_addr,
    input  logic            icache_req_ready,
    input  logic            i_cache_ready,
    input  logic            i_cache_hit,
    input  logic [XLEN-1:0] i_cache_rdata,
    output logic [XLEN-1:0] IF_ID_PC,
    output logic [XLEN-1:0] IF_ID_Instruction,
    output logic            IF_ID_enable_out
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_miss_cycles,
    output logic [31:0]     perf_flush_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_RUN, S_WAIT, S_DROP} state_t;

    state_t            state, state_next;
    logic [XLEN-1:0]   fetch_pc, req_pc;
    logic [XLEN-1:0]   mem_pc    [DEPTH];
    logic [XLEN-1:0]   mem_instr [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              resp, accept, push, pop;

    assign resp = i_cache_ready && i_cache_hit;

    // Requests are also held off while reset is asserted so the cache sees none.
    assign icache_req_valid = reset_n && fetch_enable && (state == S_RUN) &&
                              (count < CNT_W'(DEPTH)) && !redirect_valid;
    assign icache_req_addr  = fetch_pc;
    assign accept           = icache_req_valid && icache_req_ready;

    assign IF_ID_enable_out  = (count != '0);
    assign IF_ID_PC          = IF_ID_enable_out ? mem_pc[rd_ptr]    : '0;
    assign IF_ID_Instruction = IF_ID_enable_out ? mem_instr[rd_ptr] : NOP;
    assign pop               = IF_ID_enable_out && !combined_stall && !redirect_valid;

    always_comb begin
        state_next = state;
        push       = 1'b0;
        unique case (state)
            S_RUN:  if (accept) state_next = S_WAIT;
            S_WAIT: begin
                if (redirect_valid) begin
                    state_next = resp ? S_RUN : S_DROP;
                end else if (resp) begin
                    state_next = S_RUN;
                    push       = 1'b1;
                end
            end
            S_DROP: if (resp) state_next = S_RUN;
            default: state_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= S_RUN;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            state <= state_next;
            if (accept) req_pc <= fetch_pc;
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (accept) fetch_pc <= fetch_pc + XLEN'(4);
                if (push)   wr_ptr   <= wr_ptr + PTR_W'(1);
                if (pop)    rd_ptr   <= rd_ptr + PTR_W'(1);
                if (push && !pop)      count <= count + CNT_W'(1);
                else if (pop && !push) count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            mem_pc[wr_ptr]    <= req_pc;
            mem_instr[wr_ptr] <= i_cache_rdata;
        end
    end

`ifdef IF_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_fetch_cnt   <= '0;
            perf_miss_cycles <= '0;
            perf_flush_cnt   <= '0;
        end else begin
            if (push && perf_fetch_cnt != '1)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if ((state == S_WAIT || state == S_DROP) && !resp && perf_miss_cycles != '1)
                perf_miss_cycles <= perf_miss_cycles + 32'd1;
            if (redirect_valid && perf_flush_cnt != '1)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed self-checking bench for if_fetch_queue; a small in-bench cache model
// answers accepted requests after a programmable number of miss cycles.
module tb_if_fetch_queue;

    logic        clk;
    logic        reset_n;
    logic        fetch_enable;
    logic        combined_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        icache_req_valid;
    logic [31:0] icache_req_addr;
    logic        icache_req_ready;
    logic        i_cache_ready;
    logic        i_cache_hit;
    logic [31:0] i_cache_rdata;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_Instruction;
    logic        IF_ID_enable_out;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_miss_cycles, perf_flush_cnt;
`endif

    if_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .NOP(32'h00000013)) dut (
        .clk(clk), .reset_n(reset_n), .fetch_enable(fetch_enable),
        .combined_stall(combined_stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .icache_req_valid(icache_req_valid),
        .icache_req_addr(icache_req_addr), .icache_req_ready(icache_req_ready),
        .i_cache_ready(i_cache_ready), .i_cache_hit(i_cache_hit),
        .i_cache_rdata(i_cache_rdata), .IF_ID_PC(IF_ID_PC),
        .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_enable_out(IF_ID_enable_out)
`ifdef IF_FETCH_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_miss_cycles(perf_miss_cycles),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned nvec = 0;
    int unsigned nfail = 0;

    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int unsigned wait_left = 0;
    int unsigned miss_delay = 0;
    int unsigned acc_cnt = 0;
    logic [31:0] acc_q[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_ins[$];

    function automatic logic [31:0] f(input logic [31:0] a);
        return a ^ 32'hA500_0000;
    endfunction

    // One clock: sample just before the edge, then drive the cache response for the next cycle.
    task automatic tick();
        logic acc, rsp;
        logic [31:0] a;
        #1;
        acc = icache_req_valid && icache_req_ready;
        a   = icache_req_addr;
        rsp = i_cache_ready && i_cache_hit;
        if (reset_n && IF_ID_enable_out && !combined_stall && !redirect_valid) begin
            pop_pc.push_back(IF_ID_PC);
            pop_ins.push_back(IF_ID_Instruction);
        end
        @(posedge clk);
        #1;
        if (rsp) pend = 1'b0;
        if (acc) begin
            pend = 1'b1; pend_addr = a; wait_left = miss_delay;
            acc_cnt++; acc_q.push_back(a);
        end
        if (pend && wait_left == 0) begin
            i_cache_ready = 1'b1; i_cache_hit = 1'b1; i_cache_rdata = f(pend_addr);
        end else begin
            i_cache_ready = pend & wait_left[0];
            i_cache_hit   = 1'b0;
            i_cache_rdata = 32'hDEAD_DEAD;
            if (pend) wait_left--;
        end
        #1;
    endtask

    task automatic clear_logs();
        acc_cnt = 0; acc_q.delete(); pop_pc.delete(); pop_ins.delete();
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid = 1'b1; redirect_pc = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic drain();
        fetch_enable = 1'b0; combined_stall = 1'b0; miss_delay = 0;
        repeat (12) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; fetch_enable = 1'b1;
        tick(); tick();
        nvec++; if (IF_ID_enable_out !== 1'b0) begin nfail++; $display("FAIL rst_en: got %b expected 0", IF_ID_enable_out); end
        nvec++; if (IF_ID_Instruction !== 32'h13) begin nfail++; $display("FAIL rst_instr: got %h expected 00000013", IF_ID_Instruction); end
        nvec++; if (IF_ID_PC !== 32'h0) begin nfail++; $display("FAIL rst_pc: got %h expected 0", IF_ID_PC); end
        nvec++; if (icache_req_valid !== 1'b0) begin nfail++; $display("FAIL rst_req_valid: got %b expected 0", icache_req_valid); end
        fetch_enable = 1'b0; reset_n = 1'b1;
        tick();
        nvec++; if (icache_req_addr !== 32'h0) begin nfail++; $display("FAIL rst_req_addr: got %h expected 0", icache_req_addr); end
        nvec++; if (icache_req_valid !== 1'b0) begin nfail++; $display("FAIL rst_req_idle: got %b expected 0", icache_req_valid); end
    endtask

    task automatic test_stream();
        redirect_to(32'h0);
        clear_logs();
        fetch_enable = 1'b1;
        repeat (16) tick();
        nvec++; if (pop_pc.size() != 7) begin nfail++; $display("FAIL stream_rate: got %0d pops expected 7", pop_pc.size()); end
        fetch_enable = 1'b0;
        repeat (6) tick();
        nvec++; if (pop_pc.size() != 8) begin nfail++; $display("FAIL stream_total: got %0d pops expected 8", pop_pc.size()); end
        for (int i = 0; i < 8; i++) begin
            if (i < pop_pc.size()) begin
                nvec++; if (pop_pc[i] !== 32'(4 * i)) begin nfail++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, pop_pc[i], 32'(4 * i)); end
                nvec++; if (pop_ins[i] !== f(32'(4 * i))) begin nfail++; $display("FAIL stream_ins[%0d]: got %h expected %h", i, pop_ins[i], f(32'(4 * i))); end
            end
        end
        drain();
    endtask

    task automatic test_stall();
        logic [31:0] exp_pc [5];
        exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8; exp_pc[3] = 32'hC; exp_pc[4] = 32'h10;
        redirect_to(32'h0);
        clear_logs();
        combined_stall = 1'b1; fetch_enable = 1'b1;
        repeat (10) tick();
        nvec++; if (acc_cnt != 4) begin nfail++; $display("FAIL stall_reqs: got %0d expected 4", acc_cnt); end
        nvec++; if (icache_req_valid !== 1'b0) begin nfail++; $display("FAIL stall_req_valid: got %b expected 0", icache_req_valid); end
        nvec++; if (IF_ID_PC !== 32'h0) begin nfail++; $display("FAIL stall_head_pc: got %h expected 0", IF_ID_PC); end
        nvec++; if (IF_ID_Instruction !== f(32'h0)) begin nfail++; $display("FAIL stall_head_ins: got %h expected %h", IF_ID_Instruction, f(32'h0)); end
        nvec++; if (pop_pc.size() != 0) begin nfail++; $display("FAIL stall_no_pop: got %0d expected 0", pop_pc.size()); end
        combined_stall = 1'b0;
        repeat (12) tick();
        nvec++; if (pop_pc.size() < 5) begin nfail++; $display("FAIL stall_release_cnt: got %0d expected >=5", pop_pc.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < pop_pc.size()) begin
                nvec++; if (pop_pc[i] !== exp_pc[i]) begin nfail++; $display("FAIL stall_order[%0d]: got %h expected %h", i, pop_pc[i], exp_pc[i]); end
            end
        end
        drain();
    endtask

    task automatic test_miss();
        redirect_to(32'h20);
        clear_logs();
        miss_delay = 8; fetch_enable = 1'b1;
        tick();
        nvec++; if (acc_q.size() != 1 || acc_q[0] !== 32'h20) begin nfail++; $display("FAIL miss_req_addr: got %0d reqs expected one at 00000020", acc_q.size()); end
        repeat (8) tick();
        nvec++; if (acc_cnt != 1) begin nfail++; $display("FAIL miss_no_dup: got %0d reqs expected 1", acc_cnt); end
        nvec++; if (IF_ID_enable_out !== 1'b0) begin nfail++; $display("FAIL miss_empty: got %b expected 0", IF_ID_enable_out); end
        fetch_enable = 1'b0;
        repeat (3) tick();
        nvec++; if (pop_pc.size() != 1) begin nfail++; $display("FAIL miss_single: got %0d pops expected 1", pop_pc.size()); end
        if (pop_pc.size() != 0) begin
            nvec++; if (pop_pc[0] !== 32'h20) begin nfail++; $display("FAIL miss_pc: got %h expected 00000020", pop_pc[0]); end
            nvec++; if (pop_ins[0] !== f(32'h20)) begin nfail++; $display("FAIL miss_ins: got %h expected %h", pop_ins[0], f(32'h20)); end
        end
        drain();
    endtask

    task automatic test_redirect_wait();
        redirect_to(32'h40);
        clear_logs();
        miss_delay = 3; fetch_enable = 1'b1;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        #1;
        nvec++; if (icache_req_valid !== 1'b0) begin nfail++; $display("FAIL redir_req_valid: got %b expected 0", icache_req_valid); end
        miss_delay = 0;
        tick();
        redirect_valid = 1'b0;
        nvec++; if (IF_ID_enable_out !== 1'b0) begin nfail++; $display("FAIL redir_empty: got %b expected 0", IF_ID_enable_out); end
        clear_logs();
        repeat (10) tick();
        nvec++; if (acc_q.size() == 0 || acc_q[0] !== 32'h100) begin nfail++; $display("FAIL redir_next_req: got %0d reqs expected first at 00000100", acc_q.size()); end
        nvec++; if (pop_pc.size() == 0 || pop_pc[0] !== 32'h100) begin nfail++; $display("FAIL redir_first_pc: got %0d pops expected first 00000100", pop_pc.size()); end
        if (pop_ins.size() != 0) begin
            nvec++; if (pop_ins[0] !== f(32'h100)) begin nfail++; $display("FAIL redir_first_ins: got %h expected %h", pop_ins[0], f(32'h100)); end
        end
        drain();
    endtask

    task automatic test_redirect_same_cycle();
        redirect_to(32'h200);
        clear_logs();
        combined_stall = 1'b1; fetch_enable = 1'b1;
        tick(); tick(); tick();
        combined_stall = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h300;
        #1;
        nvec++; if (IF_ID_enable_out !== 1'b1) begin nfail++; $display("FAIL same_head_valid: got %b expected 1", IF_ID_enable_out); end
        tick();
        redirect_valid = 1'b0; fetch_enable = 1'b0;
        nvec++; if (IF_ID_enable_out !== 1'b0) begin nfail++; $display("FAIL same_empty: got %b expected 0", IF_ID_enable_out); end
        nvec++; if (IF_ID_Instruction !== 32'h13) begin nfail++; $display("FAIL same_nop: got %h expected 00000013", IF_ID_Instruction); end
        nvec++; if (IF_ID_PC !== 32'h0) begin nfail++; $display("FAIL same_pc: got %h expected 0", IF_ID_PC); end
        nvec++; if (icache_req_addr !== 32'h300) begin nfail++; $display("FAIL same_fetch_pc: got %h expected 00000300", icache_req_addr); end
        repeat (4) tick();
        nvec++; if (pop_pc.size() != 0) begin nfail++; $display("FAIL same_no_pop: got %0d expected 0", pop_pc.size()); end
        drain();
    endtask

    task automatic test_reset_wait();
        redirect_to(32'h500);
        clear_logs();
        miss_delay = 4; fetch_enable = 1'b1;
        tick();
        fetch_enable = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        nvec++; if (IF_ID_enable_out !== 1'b0) begin nfail++; $display("FAIL rstw_en: got %b expected 0", IF_ID_enable_out); end
        nvec++; if (icache_req_valid !== 1'b0) begin nfail++; $display("FAIL rstw_req_valid: got %b expected 0", icache_req_valid); end
        nvec++; if (icache_req_addr !== 32'h0) begin nfail++; $display("FAIL rstw_req_addr: got %h expected 0", icache_req_addr); end
        reset_n = 1'b1;
        repeat (6) tick();
        nvec++; if (IF_ID_enable_out !== 1'b0) begin nfail++; $display("FAIL rstw_stale_ignored: got %b expected 0", IF_ID_enable_out); end
        nvec++; if (IF_ID_Instruction !== 32'h13) begin nfail++; $display("FAIL rstw_nop: got %h expected 00000013", IF_ID_Instruction); end
        drain();
    endtask

`ifdef IF_FETCH_PERF_EN
    task automatic test_perf();
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        redirect_to(32'h0);
        clear_logs();
        miss_delay = 5; fetch_enable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (acc_cnt >= 1) miss_delay = 0;
            if (acc_cnt >= 3) break;
        end
        fetch_enable = 1'b0;
        repeat (6) tick();
        nvec++; if (perf_fetch_cnt !== 32'd3) begin nfail++; $display("FAIL perf_fetch: got %0d expected 3", perf_fetch_cnt); end
        nvec++; if (perf_miss_cycles !== 32'd5) begin nfail++; $display("FAIL perf_miss: got %0d expected 5", perf_miss_cycles); end
        nvec++; if (perf_flush_cnt !== 32'd1) begin nfail++; $display("FAIL perf_flush: got %0d expected 1", perf_flush_cnt); end
        drain();
    endtask
`endif

    initial begin
        reset_n = 1'b0; fetch_enable = 1'b0; combined_stall = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; icache_req_ready = 1'b1;
        i_cache_ready = 1'b0; i_cache_hit = 1'b0; i_cache_rdata = '0;
        test_reset();
        test_stream();
        test_stall();
        test_miss();
        test_redirect_wait();
        test_redirect_same_cycle();
        test_reset_wait();
`ifdef IF_FETCH_PERF_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
